// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one async_fifo write port among NREQ write-domain requesters.
// An owner may write up to BURST consecutive words before the port rotates to the next requester.
module fifo_write_arbiter #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned NREQ  = 2,
  parameter int unsigned BURST = 2
) (
  input  logic                    wclk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   din,
  input  logic                    full,
  output logic [NREQ-1:0]         gnt,
  output logic                    we,
  output logic [WIDTH-1:0]        wdata,
  output logic                    busy
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW = $clog2(BURST + 1);
  localparam logic [CntW-1:0] BurstCnt = CntW'(BURST);

  typedef enum logic [0:0] {StIdle, StOwn} state_e;

  state_e            state_q;
  logic [IdxW-1:0]   owner_q;
  logic [IdxW-1:0]   ptr_q;
  logic [CntW-1:0]   cnt_q;

  logic              cont;
  logic              sel_valid;
  logic [IdxW-1:0]   sel;
  logic [IdxW-1:0]   start_idx;
  logic [IdxW-1:0]   scan_idx;
  logic              grant;

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] i);
    if (32'(i) == NREQ - 1) return '0;
    return i + IdxW'(1);
  endfunction

  always_comb begin
    cont      = (state_q == StOwn) && req[owner_q] && (cnt_q < BurstCnt);
    start_idx = (state_q == StOwn) ? next_idx(owner_q) : ptr_q;
    sel_valid = 1'b0;
    sel       = '0;
    scan_idx  = start_idx;
    if (cont) begin
      sel_valid = 1'b1;
      sel       = owner_q;
    end else begin
      // First requesting index at or after start_idx, wrapping modulo NREQ.
      for (int unsigned k = 0; k < NREQ; k++) begin
        if (!sel_valid && req[scan_idx]) begin
          sel_valid = 1'b1;
          sel       = scan_idx;
        end
        scan_idx = next_idx(scan_idx);
      end
    end
  end

  // Reset gates the outputs so a transfer coinciding with reset never reaches the FIFO.
  assign grant = sel_valid && !full && !rst;

  always_comb begin
    gnt   = '0;
    wdata = '0;
    if (grant) begin
      gnt[sel] = 1'b1;
      wdata    = din[32'(sel)*WIDTH +: WIDTH];
    end
  end

  assign we   = grant;
  assign busy = !rst && (state_q == StOwn);

  always_ff @(posedge wclk) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else if (!full) begin
      if (sel_valid) begin
        state_q <= StOwn;
        if (cont) begin
          cnt_q <= cnt_q + CntW'(1);
        end else begin
          owner_q <= sel;
          cnt_q   <= CntW'(1);
        end
      end else begin
        state_q <= StIdle;
        if (state_q == StOwn) ptr_q <= next_idx(owner_q);
      end
    end
  end

endmodule
